// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle for uart_rx_param: serial input, oversample tick and the word handshake.
// master is the receiver; slave is the baud-generator / pad / consumer side.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic                 i_tick;
  logic                 i_rx;
  logic                 i_ready;
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_err;
  logic                 o_parity_err;
  logic                 o_overrun;
  logic                 o_busy;

  modport master (
    input  i_tick, i_rx, i_ready,
    output o_data, o_valid, o_frame_err, o_parity_err, o_overrun, o_busy
  );

  modport slave (
    output i_tick, i_rx, i_ready,
    input  o_data, o_valid, o_frame_err, o_parity_err, o_overrun, o_busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver, LSB first, with framing/parity/overrun flags and a held output word.
// Define UART_RX_PARITY_EN to add the parity bit state and o_parity_err checking.
module uart_rx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic              i_clock,
  input logic              i_reset_n,
  uart_rx_param_if.master  bus
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] CntMid      = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntEnd      = CntW'(OVERSAMPLE - 1);
  localparam logic [IdxW-1:0] IdxDataLast = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] IdxStopLast = IdxW'(STOP_BITS - 1);

  if (!(DATA_BITS >= 5 && DATA_BITS <= 9 && OVERSAMPLE >= 4 && OVERSAMPLE % 2 == 0 &&
        (STOP_BITS == 1 || STOP_BITS == 2) && PARITY_ODD <= 1)) begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 fe_acc_q, fe_acc_d;
  logic                 brk_q, brk_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic                 rxs, fe_now, commit;
`ifdef UART_RX_PARITY_EN
  logic                 pe_q, pe_d;
`endif

  assign rxs    = rx_sync_q;
  assign fe_now = fe_acc_q | ~rxs;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fe_acc_d = fe_acc_q;
    brk_d    = brk_q;
    commit   = 1'b0;
`ifdef UART_RX_PARITY_EN
    pe_d     = pe_q;
`endif
    unique case (state_q)
      StIdle: begin
        // After a framing error the line must return high before a new start is accepted.
        if (brk_q) begin
          if (rxs) brk_d = 1'b0;
        end else if (!rxs) begin
          state_d  = StStart;
          cnt_d    = '0;
          idx_d    = '0;
          fe_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          pe_d     = 1'b0;
`endif
        end
      end
      StStart: begin
        if (bus.i_tick) begin
          if (cnt_q == CntMid) begin
            cnt_d   = '0;
            state_d = rxs ? StIdle : StData;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (bus.i_tick) begin
          if (cnt_q == CntEnd) begin
            cnt_d   = '0;
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            if (idx_q == IdxDataLast) begin
              idx_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (bus.i_tick) begin
          if (cnt_q == CntEnd) begin
            cnt_d   = '0;
            pe_d    = rxs ^ (^shift_q) ^ 1'(PARITY_ODD);
            state_d = StStop;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif
      StStop: begin
        if (bus.i_tick) begin
          if (cnt_q == CntEnd) begin
            cnt_d    = '0;
            fe_acc_d = fe_now;
            // Commit at mid-stop so a back-to-back start edge is never missed.
            if (idx_q == IdxStopLast) begin
              commit  = 1'b1;
              brk_d   = fe_now;
              state_d = StIdle;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    valid_d = valid_q & ~bus.i_ready;
    ovr_d   = 1'b0;
    if (commit) begin
      data_d  = shift_q;
      ferr_d  = fe_now;
`ifdef UART_RX_PARITY_EN
      perr_d  = pe_q;
`else
      perr_d  = 1'b0;
`endif
      valid_d = 1'b1;
      ovr_d   = valid_q & ~bus.i_ready;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      fe_acc_q  <= 1'b0;
      brk_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= bus.i_rx;
      rx_sync_q <= rx_meta_q;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      fe_acc_q  <= fe_acc_d;
      brk_q     <= brk_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
      pe_q      <= pe_d;
`endif
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_frame_err  = ferr_q;
  assign bus.o_parity_err = perr_q;
  assign bus.o_overrun    = ovr_q;
  assign bus.o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: frames are modelled bit-by-bit from the line protocol,
// expected words are queued at frame start and checked by a monitor on each accepted word.
module tb_uart_rx_param;

  localparam int unsigned DataBits = 8;
  localparam int unsigned Os       = 16;
  localparam int unsigned StopBits = 1;
  localparam int unsigned ParOdd   = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit ParityOn = 1'b1;
`else
  localparam bit ParityOn = 1'b0;
`endif

  typedef struct packed {
    logic [DataBits-1:0] data;
    logic                ferr;
    logic                perr;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(DataBits)) bus ();

  uart_rx_param #(
    .DATA_BITS (DataBits),
    .OVERSAMPLE(Os),
    .STOP_BITS (StopBits),
    .PARITY_ODD(ParOdd)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   n_ovr      = 0;
  int   n_acc      = 0;
  int   tick_div   = 1;
  int   ready_mode = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Oversample tick generator: one pulse every tick_div clocks.
  initial begin
    int ph;
    ph = 0;
    bus.i_tick = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_tick = (ph == 0);
      ph = (ph + 1 >= tick_div) ? 0 : ph + 1;
    end
  end

  // Consumer and monitor: drives i_ready and checks every word the DUT hands over.
  initial begin
    exp_t e;
    bus.i_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.i_ready = 1'b0;
      end else begin
        if (bus.o_overrun) begin
          n_ovr++;
          check("overrun_has_lost_word", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) e = sb.pop_front();
        end
        case (ready_mode)
          0:       bus.i_ready = 1'b0;
          1:       bus.i_ready = 1'b1;
          default: bus.i_ready = ($urandom_range(3) != 0);
        endcase
        if (bus.o_valid && bus.i_ready) begin
          n_acc++;
          check("word_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("data", 32'(bus.o_data), 32'(e.data));
            check("frame_err", 32'(bus.o_frame_err), 32'(e.ferr));
            check("parity_err", 32'(bus.o_parity_err), 32'(e.perr));
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (bus.i_tick) k++;
    end
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.i_rx = b;
    wait_ticks(Os);
  endtask

  // Reference: word = data bits, frame error if any stop bit is 0,
  // parity error if data plus parity bit has the wrong ones-count for the chosen sense.
  task automatic send_frame(input logic [DataBits-1:0] d, input logic stop_v,
                            input logic par_flip, input int abort_bit);
    logic pbit;
    exp_t e;
    pbit   = (^d) ^ 1'(ParOdd) ^ par_flip;
    e.data = d;
    e.ferr = ~stop_v;
    e.perr = ParityOn && (((^d) ^ pbit) != 1'(ParOdd));
    if (abort_bit < 0) sb.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < int'(DataBits); i++) begin
      if (i == abort_bit) begin
        bus.i_rx = d[i];
        wait_ticks(Os / 2);
        return;
      end
      send_bit(d[i]);
    end
    if (ParityOn) send_bit(pbit);
    for (int i = 0; i < int'(StopBits); i++) send_bit(stop_v);
    bus.i_rx = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20000 && sb.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},   32'(bus.o_data), 32'd0);
    check({tag, "_valid"},  32'(bus.o_valid), 32'd0);
    check({tag, "_ferr"},   32'(bus.o_frame_err), 32'd0);
    check({tag, "_perr"},   32'(bus.o_parity_err), 32'd0);
    check({tag, "_ovr"},    32'(bus.o_overrun), 32'd0);
    check({tag, "_busy"},   32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    int acc0, ovr0, gap;
    logic stop_v;
    bus.i_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_ticks(4);

    // Basic frame
    send_frame(8'hA5, 1'b1, 1'b0, -1);
    wait_ticks(4);
    drain("drain_a5");
    check("no_overrun_a5", 32'(n_ovr), 32'd0);

    // Short low pulse on the line is rejected at mid-start
    acc0 = n_acc;
    bus.i_rx = 1'b0;
    wait_ticks(5);
    check("glitch_busy", 32'(bus.o_busy), 32'd1);
    bus.i_rx = 1'b1;
    wait_ticks(Os);
    check("glitch_idle", 32'(bus.o_busy), 32'd0);
    check("glitch_no_valid", 32'(bus.o_valid), 32'd0);
    check("glitch_no_word", 32'(n_acc - acc0), 32'd0);

    // Stop bit forced low, then a clean frame after the line recovers
    send_frame(8'h3C, 1'b0, 1'b0, -1);
    wait_ticks(4);
    send_frame(8'h55, 1'b1, 1'b0, -1);
    wait_ticks(4);
    drain("drain_framing");

    // Line break: one word of zeros with frame error and nothing more while low
    begin
      exp_t e;
      e.data = '0;
      e.ferr = 1'b1;
      e.perr = ParityOn && (1'b0 != 1'(ParOdd));
      sb.push_back(e);
    end
    acc0 = n_acc;
    bus.i_rx = 1'b0;
    wait_ticks(Os * (3 + DataBits + (ParityOn ? 1 : 0) + StopBits));
    bus.i_rx = 1'b1;
    wait_ticks(Os * 2);
    drain("drain_break");
    check("break_one_word", 32'(n_acc - acc0), 32'd1);

    // Parity bit correct, then inverted
    send_frame(8'h07, 1'b1, 1'b0, -1);
    wait_ticks(2);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    wait_ticks(2);
    drain("drain_parity");

    // Overrun: consumer stalled across two back-to-back frames
    ready_mode = 0;
    ovr0 = n_ovr;
    send_frame(8'h11, 1'b1, 1'b0, -1);
    send_frame(8'h22, 1'b1, 1'b0, -1);
    wait_ticks(Os);
    check("overrun_once", 32'(n_ovr - ovr0), 32'd1);
    check("overrun_valid", 32'(bus.o_valid), 32'd1);
    check("overrun_data", 32'(bus.o_data), 32'h22);
    ready_mode = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("accept_clears_valid", 32'(bus.o_valid), 32'd0);
    drain("drain_overrun");

    // Reset in the middle of a frame abandons it
    acc0 = n_acc;
    send_frame(8'hFF, 1'b1, 1'b0, 3);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.i_rx = 1'b1;
    wait_ticks(Os * DataBits);
    send_frame(8'h81, 1'b1, 1'b0, -1);
    wait_ticks(4);
    drain("drain_after_reset");
    check("after_reset_one_word", 32'(n_acc - acc0), 32'd1);

    // Randomized frames, tick rates and consumer backpressure
    ready_mode = 2;
    for (int f = 0; f < 24; f++) begin
      tick_div = int'($urandom_range(1, 3));
      stop_v = ($urandom_range(5) != 0);
      gap = stop_v ? int'($urandom_range(0, Os)) : int'($urandom_range(4, Os));
      send_frame(DataBits'($urandom), stop_v, 1'($urandom_range(1)), -1);
      if (gap > 0) wait_ticks(gap);
    end
    drain("drain_random");
    ready_mode = 1;
    tick_div = 1;
    wait_ticks(4);
    check("final_idle", 32'(bus.o_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
